// File: rtl/mux21_arbiter.sv
// rtl/mux21_arbiter.sv - round-robin arbiter sharing a 2:1 data mux between two requesters
// Every uo_out bit is a flop loaded from the next state, so outputs carry no combinational path.
module mux21_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {S_IDLE, S_GNT0, S_GNT1} state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);
  localparam logic [3:0] HOLD_END = 4'(MAX_HOLD - 1);

  state_t     r_state;
  state_t     w_next;
  logic       r_last;
  logic [3:0] r_cnt;

  logic       w_req0;
  logic       w_req1;
  logic [3:0] w_data0;
  logic [3:0] w_data1;
  logic       w_expired;
  logic       w_unused;

  assign w_req0    = ui_in[0];
  assign w_req1    = ui_in[1];
  assign w_data0   = ui_in[5:2];
  assign w_data1   = uio_in[3:0];
  // Counter is 0 during the first grant cycle, so MAX_HOLD cycles have elapsed at MAX_HOLD-1.
  assign w_expired = (r_cnt >= HOLD_END);
  assign w_unused  = &{1'b0, ena, ui_in[7:6], uio_in[7:4]};

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req0 && (!w_req1 || r_last)) w_next = S_GNT0;
        else if (w_req1)                   w_next = S_GNT1;
      end
      S_GNT0: begin
        if (!w_req0 || (w_expired && w_req1)) w_next = S_IDLE;
      end
      S_GNT1: begin
        if (!w_req1 || (w_expired && w_req0)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_cnt   <= 4'd0;
      uo_out  <= 8'h00;
    end else begin
      r_state <= w_next;

      if (r_state == S_IDLE) begin
        r_cnt <= 4'd0;
        if (w_next == S_GNT0) r_last <= 1'b0;
        if (w_next == S_GNT1) r_last <= 1'b1;
      end else if ((w_next != S_IDLE) && (r_cnt != HOLD_MAX)) begin
        r_cnt <= r_cnt + 4'd1;
      end

      case (w_next)
        S_GNT0:  uo_out <= {w_data0, 4'b1001};
        S_GNT1:  uo_out <= {w_data1, 4'b1110};
        default: uo_out <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_mux21_arbiter.sv
// tb/tb_mux21_arbiter.sv - self-checking bench for mux21_arbiter against a grant-length model
module tb_mux21_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks;
  int n_pass;

  int m_owner;
  int m_len;
  int m_last;
  logic [7:0] m_exp;

  mux21_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_len   = 0;
    m_last  = 1;
    m_exp   = 8'h00;
  endtask

  // Owner -1 is idle; m_len counts how many cycles the current grant has been visible.
  task automatic model_step(input bit r0, input bit r1, input logic [3:0] d0, input logic [3:0] d1);
    bit mine;
    bit other;
    if (m_owner < 0) begin
      if (r0 && r1)  m_owner = (m_last == 1) ? 0 : 1;
      else if (r0)   m_owner = 0;
      else if (r1)   m_owner = 1;
      if (m_owner >= 0) begin
        m_last = m_owner;
        m_len  = 1;
      end
    end else begin
      mine  = (m_owner == 0) ? r0 : r1;
      other = (m_owner == 0) ? r1 : r0;
      if (!mine || (m_len >= MAX_HOLD && other)) m_owner = -1;
      else m_len++;
    end
    case (m_owner)
      0:       m_exp = {d0, 4'b1001};
      1:       m_exp = {d1, 4'b1110};
      default: m_exp = 8'h00;
    endcase
  endtask

  task automatic cycle(input bit r0, input bit r1, input logic [3:0] d0, input logic [3:0] d1);
    @(negedge clk);
    ui_in  = {2'($urandom_range(0, 3)), d0, r1, r0};
    uio_in = {4'($urandom_range(0, 15)), d1};
    ena    = 1'b1;
    @(posedge clk);
    model_step(r0, r1, d0, d1);
    #1;
    check("model_uo_out", uo_out, m_exp);
    check("uio_out_zero", uio_out, 8'h00);
    check("uio_oe_zero", uio_oe, 8'h00);
    check("no_overlap", {7'd0, uo_out[1:0] == 2'b11}, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    bit r0;
    bit r1;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b1;
    ena      = 1'b1;
    ui_in    = 8'h00;
    uio_in   = 8'h00;
    model_reset();
    #2;
    do_reset();
    #1;
    check("reset_uo_out", uo_out, 8'h00);

    // single requester with changing data
    cycle(1, 0, 4'h5, 4'h3);
    check("single_first", uo_out, 8'h59);
    cycle(1, 0, 4'h6, 4'h3);
    check("single_second", uo_out, 8'h69);
    cycle(0, 0, 4'h6, 4'h3);
    check("single_release", uo_out, 8'h00);

    // tie from reset release: 8 x gnt0, gap, 8 x gnt1, gap, gnt0
    do_reset();
    for (int i = 0; i < MAX_HOLD; i++) begin
      cycle(1, 1, 4'h2, 4'h9);
      check("tie_gnt0", uo_out, 8'h29);
    end
    cycle(1, 1, 4'h2, 4'h9);
    check("tie_gap1", {7'd0, uo_out[3]}, 8'h00);
    for (int i = 0; i < MAX_HOLD; i++) begin
      cycle(1, 1, 4'h2, 4'h9);
      check("tie_gnt1", uo_out, 8'h9E);
    end
    cycle(1, 1, 4'h2, 4'h9);
    check("tie_gap2", uo_out, 8'h00);
    cycle(1, 1, 4'h2, 4'h9);
    check("tie_regrant0", uo_out, 8'h29);

    // release/request collision
    cycle(0, 0, 4'h0, 4'h0);
    cycle(1, 0, 4'h1, 4'h4);
    cycle(0, 1, 4'h1, 4'h4);
    check("collide_gap", uo_out, 8'h00);
    cycle(0, 1, 4'h1, 4'h4);
    check("collide_gnt1", uo_out, 8'h4E);
    cycle(0, 0, 4'h1, 4'h4);

    // saturating hold then preemption within one cycle
    for (int i = 0; i < 40; i++) begin
      cycle(0, 1, 4'h7, 4'hB);
      check("sat_gnt1", uo_out, 8'hBE);
    end
    cycle(1, 1, 4'h7, 4'hB);
    check("sat_preempt", uo_out, 8'h00);
    cycle(1, 1, 4'h7, 4'hB);
    check("sat_then_gnt0", uo_out, 8'h79);
    cycle(0, 0, 4'h7, 4'hB);

    // one-cycle pulse
    cycle(0, 0, 4'h0, 4'h0);
    cycle(0, 1, 4'h3, 4'hC);
    check("pulse_gnt1", uo_out, 8'hCE);
    cycle(0, 0, 4'h3, 4'hC);
    check("pulse_end", uo_out, 8'h00);

    // asynchronous reset in the middle of a grant
    cycle(0, 1, 4'h0, 4'hA);
    cycle(0, 1, 4'h0, 4'hA);
    check("pre_reset_gnt1", uo_out, 8'hAE);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", uo_out, 8'h00);
    do_reset();
    cycle(1, 1, 4'h5, 4'hA);
    check("post_reset_tie", uo_out, 8'h59);

    // randomized sticky requests against the model
    r0 = 1'b0;
    r1 = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) r0 = ~r0;
      if ($urandom_range(0, 7) == 0) r1 = ~r1;
      cycle(r0, r1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux21_arbiter.md
# mux21_arbiter

Round-robin arbiter that shares the 2:1 output multiplexer between two requesters on a Tiny Tapeout tile. Each requester raises a request, receives an exclusive registered grant, and its 4-bit data word is steered to the output through the mux select the arbiter drives. A hold timer bounds grant length while the other side is waiting. A one-cycle idle gap separates any two grants, so grants never overlap.

## Interface
- `MAX_HOLD`, default 8: maximum grant length in cycles while the other requester waits. Legal range is 2..15.

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `ena`  input  1  always 1 when powered; ignored.
- `ui_in`  input  8  bit 0 `req0`; bit 1 `req1`; bits 5:2 `data0[3:0]`; bits 7:6 unused.
- `uio_in`  input  8  bits 3:0 `data1[3:0]`; bits 7:4 unused.
- `uo_out`  output  8  bit 0 `gnt0`; bit 1 `gnt1`; bit 2 `sel`; bit 3 `busy`; bits 7:4 `y[3:0]`.
- `uio_out`  output  8  constant 0.
- `uio_oe`  output  8  constant 0, so all bidirectional pins are inputs.
- All `uo_out` bits are registered; there is no combinational path from inputs to outputs.

## Operation
- **States:** IDLE, GNT0, GNT1. A one-bit `last` pointer records the most recently granted requester.
- **Reset (async):** state = IDLE, `last` = 1 (so `req0` wins the first tie), hold counter = 0, and all of `uo_out` = 0x00.
- **IDLE to grant:**
  - Only `req0` sampled high: go to GNT0.
  - Only `req1` sampled high: go to GNT1.
  - Both high: grant the requester that is not `last`.
  - Neither high: stay in IDLE.
- **On entering GNTx:** set `last` = x and clear the hold counter.
- **GNTx to IDLE** happens on either condition:
  - `reqx` is sampled low (voluntary release).
  - The hold counter shows the grant has lasted `MAX_HOLD` cycles and the other request is sampled high (preemption).
- **GNTx with no exit condition:** stay in GNTx.
  - The hold counter increments each cycle and saturates at `MAX_HOLD`.
  - If the other side stays idle, a grant may last indefinitely.
- **No direct handoff:** GNT0 to GNT1 always passes through IDLE for at least one cycle.
- **Output fields:**
  - `gnt0` = (state == GNT0).
  - `gnt1` = (state == GNT1).
  - `busy` = (state != IDLE).
  - `sel` = 1 in GNT1, 0 otherwise.
  - `y` in GNT0 is `data0` registered each cycle; in GNT1 it is `data1` registered each cycle; in IDLE it is 0x0.
- **Width:** `y` is 4 bits. The data inputs pass through unmodified, with no arithmetic.
- **Unused inputs** (`ena`, `ui_in[7:6]`, `uio_in[7:4]`) are consumed only to suppress lint warnings.

## Timing
- **Grant latency:** `req` sampled high at edge k (state IDLE) gives `gnt` high after edge k, i.e. visible in cycle k+1.
- **Release latency:** `req` sampled low at edge m gives `gnt`, `busy` and `sel` low after edge m, and `y` = 0 after edge m.
- **Data latency:** `y` after edge n equals the granted requester's data sampled at edge n.
- **Preemption:** while the other request stays high, `gnt` is high for exactly `MAX_HOLD` consecutive cycles, followed by 1 IDLE cycle, then the other grant.
- **Boundary conditions:**
  - Release sampled at the same edge as the other requester's rise: IDLE for one cycle, then the other is granted.
  - Preempted requester still requesting: it is re-granted only after the other requester's grant ends (round-robin via `last`).
  - Gap-cycle target drops its request while the preempted one still requests: the preempted one is granted (the only request present).
  - Request pulse of 1 cycle sampled in IDLE: a grant of exactly 1 cycle, since `req` is sampled low at the next edge.
  - `rst_n` low mid-grant: all outputs are 0 immediately, without waiting for `clk`. After release, the first tie goes to `req0`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-GNT1 with `data1`=0xA. Outputs must go to `uo_out`=0x00 asynchronously, before the next clk edge. After release, both requests high gives `gnt0` first.
- **Single requester:** `req0`=1, `data0`=0x5, then `data0`=0x6 one cycle later. Expect `uo_out`=0x59 after the first edge, then 0x69. After `req0` drops, expect 0x00.
- **Tie and round-robin:** with `MAX_HOLD`=8 and both requests held high from reset release, expect `gnt0` for 8 cycles, 1 gap with `busy`=0, `gnt1` for 8 cycles with `sel`=1, 1 gap, then `gnt0` again.
- **Release/request collision:** GNT0 active; `req0` falls at the same edge that `req1` rises. Expect exactly one IDLE cycle, then `gnt1`, with `gnt0` and `gnt1` never high together.
- **Saturating hold:** `req1` held for 40 cycles with `req0`=0. `gnt1` stays high throughout. Raising `req0` at cycle 40 ends `gnt1` within 1 cycle, since the counter is already saturated; after the gap, `gnt0` follows.
- **Short pulse:** a 1-cycle `req1` pulse from IDLE produces a 1-cycle `gnt1` with `y`=`data1`, and `uio_oe`/`uio_out` are checked to be 0x00 at all times.
